cache_line_mem_if: RTL and testbench

- Memory-side stage directly downstream of the 4-way set-associative cache controller.
- Takes one line-level request per miss: an optional dirty-victim writeback followed by a mandatory line fill.
- Serializes each 512-bit line into 16 single-word beats on a 32-bit memory command bus and reassembles fill data into a full line.
- Returns the filled line to the controller with a one-cycle completion pulse.

---
 rtl/cache_line_mem_if.sv | 164 ++++++++++++++++
 tb/tb_cache_line_mem_if.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_mem_if.sv
// Memory-side line engine: optional victim writeback, then a line fill,
// serialized as single-word beats and reassembled into a full line.
module cache_line_mem_if #(
    parameter int ADDR_BITS      = 32,
    parameter int WORD_BITS      = 32,
    parameter int WORDS_PER_LINE = 16,
    parameter int LINE_BITS      = WORD_BITS * WORDS_PER_LINE,
    parameter int OFFSET_BITS    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wb,
    input  logic [ADDR_BITS-1:0] req_wb_addr,
    input  logic [LINE_BITS-1:0] req_wb_data,
    input  logic [ADDR_BITS-1:0] req_fill_addr,
    output logic                 resp_valid,
    output logic [LINE_BITS-1:0] resp_data,
    output logic                 mem_cmd_valid,
    input  logic                 mem_cmd_ready,
    output logic                 mem_cmd_we,
    output logic [ADDR_BITS-1:0] mem_cmd_addr,
    output logic [WORD_BITS-1:0] mem_wdata,
    input  logic                 mem_rdata_valid,
    input  logic [WORD_BITS-1:0] mem_rdata
);

    localparam int BW    = $clog2(WORDS_PER_LINE);
    localparam int CW    = BW + 1;
    localparam int BSH   = $clog2(WORD_BITS / 8);
    localparam logic [BW-1:0] LAST = BW'(WORDS_PER_LINE - 1);
    localparam logic [CW-1:0] FULL = CW'(WORDS_PER_LINE);
    localparam logic [ADDR_BITS-1:0] BASE_MASK =
        {{(ADDR_BITS-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB,
        S_RD,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [ADDR_BITS-1:0] r_wb_base;
    logic [ADDR_BITS-1:0] r_fill_base;
    logic [LINE_BITS-1:0] r_wb_data;
    logic [LINE_BITS-1:0] r_resp_data;
    logic [BW-1:0]        r_beat;
    logic [CW-1:0]        r_acc;
    logic [CW-1:0]        r_rcv;

    logic                 w_accept;
    logic                 w_fire;
    logic                 w_last;
    logic                 w_take;
    logic [CW-1:0]        w_outstanding;
    logic [ADDR_BITS-1:0] w_beat_off;

    assign w_accept      = req_valid && (r_state == S_IDLE);
    assign mem_cmd_valid = (r_state == S_WB) || (r_state == S_RD);
    assign w_fire        = mem_cmd_valid && mem_cmd_ready;
    assign w_last        = (r_beat == LAST);
    assign w_outstanding = r_acc - r_rcv;
    // Data is only meaningful while a read is in flight.
    assign w_take        = mem_rdata_valid && (w_outstanding != '0);
    assign w_beat_off    = ADDR_BITS'(r_beat) << BSH;

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_DONE);
    assign resp_data  = r_resp_data;
    assign mem_cmd_we = (r_state == S_WB);

    always_comb begin
        mem_cmd_addr = '0;
        mem_wdata    = '0;
        unique case (r_state)
            S_WB: begin
                mem_cmd_addr = r_wb_base + w_beat_off;
                mem_wdata    = r_wb_data[r_beat*WORD_BITS +: WORD_BITS];
            end
            S_RD: begin
                mem_cmd_addr = r_fill_base + w_beat_off;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = req_wb ? S_WB : S_RD;
                end
            end
            S_WB: begin
                if (w_fire && w_last) begin
                    w_next = S_RD;
                end
            end
            S_RD: begin
                if (w_fire && w_last) begin
                    w_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (r_rcv == FULL) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_base   <= '0;
            r_fill_base <= '0;
            r_wb_data   <= '0;
            r_resp_data <= '0;
            r_beat      <= '0;
            r_acc       <= '0;
            r_rcv       <= '0;
        end else if (w_accept) begin
            r_wb_base   <= req_wb_addr & BASE_MASK;
            r_fill_base <= req_fill_addr & BASE_MASK;
            r_wb_data   <= req_wb_data;
            r_beat      <= '0;
            r_acc       <= '0;
            r_rcv       <= '0;
        end else begin
            // Beat index wraps to 0 after the last writeback beat,
            // so the read phase starts without a dead cycle.
            if (w_fire) begin
                r_beat <= r_beat + 1'b1;
            end
            if (w_fire && (r_state == S_RD)) begin
                r_acc <= r_acc + 1'b1;
            end
            if (w_take) begin
                r_resp_data[r_rcv[BW-1:0]*WORD_BITS +: WORD_BITS] <= mem_rdata;
                r_rcv <= r_rcv + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_line_mem_if.sv
// Directed bench for cache_line_mem_if with a behavioural memory model.
module tb_cache_line_mem_if;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_wb;
    logic [31:0]  req_wb_addr;
    logic [511:0] req_wb_data;
    logic [31:0]  req_fill_addr;
    logic         resp_valid;
    logic [511:0] resp_data;
    logic         mem_cmd_valid;
    logic         mem_cmd_ready;
    logic         mem_cmd_we;
    logic [31:0]  mem_cmd_addr;
    logic [31:0]  mem_wdata;
    logic         mem_rdata_valid;
    logic [31:0]  mem_rdata;

    always #5 clk = ~clk;

    cache_line_mem_if dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wb         (req_wb),
        .req_wb_addr    (req_wb_addr),
        .req_wb_data    (req_wb_data),
        .req_fill_addr  (req_fill_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .mem_cmd_valid  (mem_cmd_valid),
        .mem_cmd_ready  (mem_cmd_ready),
        .mem_cmd_we     (mem_cmd_we),
        .mem_cmd_addr   (mem_cmd_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata_valid(mem_rdata_valid),
        .mem_rdata      (mem_rdata)
    );

    typedef struct packed {
        bit          wb;
        logic [31:0] wb_addr;
        logic [31:0] wb_base;
        logic [31:0] wb_word;
        logic [31:0] fill_addr;
        logic [31:0] fill_base;
        logic [31:0] fill_word;
        int          lat;
        int          mode;
        bit          spur;
        int          exp_lat;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    rd_t          q[$];
    vec_t         vecs[7];

    int           negcnt = 0;
    int           lat = 1;
    int           mode = 0;
    bit           spur = 1'b0;
    logic [31:0]  fill_wbase = '0;
    int           log_n = 0;
    int           log_start = 0;
    logic         log_we[512];
    logic [31:0]  log_addr[512];
    logic [31:0]  log_data[512];
    int           stall_left = 5;
    bit           tog = 1'b0;
    bit           pv = 1'b0;
    logic [64:0]  pv_fields = '0;
    int           stab_err = 0;
    int           resp_cnt = 0;
    logic [511:0] resp_line = '0;
    int           resp_neg = 0;
    int           acc_neg = 0;
    int           nb;
    bit           rdy;

    int           n_checks = 0;
    int           n_pass = 0;
    logic [511:0] last_line = '0;

    // Memory model: drives ready, logs accepted beats, returns read data.
    always @(negedge clk) begin
        negcnt++;
        if (!rst) begin
            q.delete();
            mem_cmd_ready   = 1'b0;
            mem_rdata_valid = 1'b0;
            mem_rdata       = '0;
            pv              = 1'b0;
        end else begin
            nb = log_n - log_start;
            if (mode == 0) begin
                rdy = 1'b1;
            end else begin
                if (nb == 0) stall_left = 5;
                if (nb == 7 && stall_left > 0 && mem_cmd_valid) begin
                    rdy = 1'b0;
                    stall_left--;
                end else begin
                    tog = !tog;
                    rdy = tog;
                end
            end
            mem_cmd_ready = rdy;
            if (pv && mem_cmd_valid &&
                pv_fields != {mem_cmd_we, mem_cmd_addr, mem_wdata}) begin
                stab_err++;
            end
            pv        = mem_cmd_valid && !rdy;
            pv_fields = {mem_cmd_we, mem_cmd_addr, mem_wdata};
            if (mem_cmd_valid && rdy) begin
                log_we[log_n]   = mem_cmd_we;
                log_addr[log_n] = mem_cmd_addr;
                log_data[log_n] = mem_wdata;
                log_n++;
                if (!mem_cmd_we) begin
                    q.push_back('{negcnt + lat,
                                  fill_wbase + 32'(mem_cmd_addr[5:2])});
                end
            end
            if (q.size() > 0 && q[0].due == negcnt) begin
                mem_rdata_valid = 1'b1;
                mem_rdata       = q[0].data;
                void'(q.pop_front());
            end else if (spur && ((mem_cmd_valid && mem_cmd_we) || req_ready)) begin
                mem_rdata_valid = 1'b1;
                mem_rdata       = 32'hDEADBEEF;
            end else begin
                mem_rdata_valid = 1'b0;
                mem_rdata       = '0;
            end
            if (resp_valid) begin
                resp_cnt++;
                resp_line = resp_data;
                resp_neg  = negcnt;
            end
            // Accept happens at the coming edge; stamp the negedge after it.
            if (req_valid && req_ready) acc_neg = negcnt + 1;
        end
    end

    task automatic chk(input bit ok, input string name,
                       input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        logic [511:0] wl;
        logic [511:0] fl;
        int           r0;
        int           s0;
        int           nexp;
        int           got;
        bit           done;
        logic [31:0]  ea;
        for (int i = 0; i < 16; i++) begin
            wl[i*32 +: 32] = v.wb_word + 32'(i);
            fl[i*32 +: 32] = v.fill_word + 32'(i);
        end
        mode       = v.mode;
        lat        = v.lat;
        fill_wbase = v.fill_word;
        if (v.spur) begin
            spur = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk(resp_data == last_line, {tag, "_spur_idle"}, resp_data, last_line);
        end
        log_start = log_n;
        r0        = resp_cnt;
        s0        = stab_err;
        @(posedge clk);
        #1;
        req_valid     = 1'b1;
        req_wb        = v.wb;
        req_wb_addr   = v.wb_addr;
        req_wb_data   = wl;
        req_fill_addr = v.fill_addr;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk(req_ready == 1'b0, {tag, "_ready_drop"}, 512'(req_ready), 512'(0));
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk);
            #1;
            if (resp_cnt > r0) done = 1'b1;
        end
        chk(done, {tag, "_resp_timeout"}, 512'(done), 512'(1));
        repeat (3) @(posedge clk);
        #1;
        spur = 1'b0;
        chk(resp_cnt - r0 == 1, {tag, "_resp_pulses"},
            512'(resp_cnt - r0), 512'(1));
        nexp = v.wb ? 32 : 16;
        got  = log_n - log_start;
        chk(got == nexp, {tag, "_beat_count"}, 512'(got), 512'(nexp));
        for (int j = 0; j < nexp && j < got; j++) begin
            if (v.wb && j < 16) begin
                ea = v.wb_base + 32'(4 * j);
                chk({log_we[log_start+j], log_addr[log_start+j],
                     log_data[log_start+j]} == {1'b1, ea, v.wb_word + 32'(j)},
                    $sformatf("%s_wbeat%0d", tag, j),
                    512'({log_we[log_start+j], log_addr[log_start+j],
                          log_data[log_start+j]}),
                    512'({1'b1, ea, v.wb_word + 32'(j)}));
            end else begin
                ea = v.fill_base + 32'(4 * (v.wb ? j - 16 : j));
                chk({log_we[log_start+j], log_addr[log_start+j]} == {1'b0, ea},
                    $sformatf("%s_rbeat%0d", tag, j),
                    512'({log_we[log_start+j], log_addr[log_start+j]}),
                    512'({1'b0, ea}));
            end
        end
        chk(resp_line == fl, {tag, "_resp_line"}, resp_line, fl);
        chk(resp_data == fl, {tag, "_resp_hold"}, resp_data, fl);
        chk(stab_err == s0, {tag, "_stall_stable"}, 512'(stab_err - s0), 512'(0));
        chk(req_ready == 1'b1, {tag, "_ready_back"}, 512'(req_ready), 512'(1));
        if (v.exp_lat != 0) begin
            chk(resp_neg - acc_neg == v.exp_lat, {tag, "_latency"},
                512'(resp_neg - acc_neg), 512'(v.exp_lat));
        end
        last_line = fl;
    endtask

    int r0m;
    int s0m;

    initial begin
        //         wb    wb_addr        wb_base        wb_word
        //               fill_addr      fill_base      fill_word    lat mode spur exp
        vecs[0] = '{1'b0, 32'h0, 32'h0, 32'h0,
                    32'h00012345, 32'h00012340, 32'hA0000000, 3, 0, 1'b0, 0};
        vecs[1] = '{1'b1, 32'h0000F000, 32'h0000F000, 32'h11110000,
                    32'h00020000, 32'h00020000, 32'h22220000, 2, 0, 1'b0, 0};
        vecs[2] = '{1'b1, 32'h00003004, 32'h00003000, 32'h33330000,
                    32'h0000407F, 32'h00004040, 32'h44440000, 1, 1, 1'b0, 0};
        vecs[3] = '{1'b0, 32'h0, 32'h0, 32'h0,
                    32'h00000100, 32'h00000100, 32'h55550000, 1, 0, 1'b0, 18};
        vecs[4] = '{1'b1, 32'h00000200, 32'h00000200, 32'h66660000,
                    32'h00000300, 32'h00000300, 32'h77770000, 1, 0, 1'b0, 34};
        vecs[5] = '{1'b1, 32'h0000A03C, 32'h0000A000, 32'h88880000,
                    32'h12345678, 32'h12345640, 32'h99990000, 2, 0, 1'b1, 0};
        vecs[6] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFC0, 32'hBBBB0000,
                    32'hFFFFFFC7, 32'hFFFFFFC0, 32'hCCCC0000, 4, 1, 1'b0, 0};

        rst           = 1'b0;
        req_valid     = 1'b0;
        req_wb        = 1'b0;
        req_wb_addr   = '0;
        req_wb_data   = '0;
        req_fill_addr = '0;
        #12;
        chk(mem_cmd_valid == 1'b0, "rst_cmd_valid", 512'(mem_cmd_valid), 512'(0));
        chk(mem_cmd_we == 1'b0, "rst_cmd_we", 512'(mem_cmd_we), 512'(0));
        chk(mem_cmd_addr == '0, "rst_cmd_addr", 512'(mem_cmd_addr), 512'(0));
        chk(mem_wdata == '0, "rst_wdata", 512'(mem_wdata), 512'(0));
        chk(resp_valid == 1'b0, "rst_resp_valid", 512'(resp_valid), 512'(0));
        chk(resp_data == '0, "rst_resp_data", resp_data, 512'(0));
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk(req_ready == 1'b1, "rst_req_ready", 512'(req_ready), 512'(1));

        for (int k = 0; k < 7; k++) begin
            run_txn(vecs[k], $sformatf("v%0d", k));
        end

        // Abort a writeback while beat 9 is on the bus.
        mode       = 0;
        lat        = 2;
        fill_wbase = 32'hEEEE0000;
        log_start  = log_n;
        r0m        = resp_cnt;
        s0m        = 0;
        @(posedge clk);
        #1;
        req_valid     = 1'b1;
        req_wb        = 1'b1;
        req_wb_addr   = 32'h00005000;
        req_fill_addr = 32'h00006000;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (log_n - log_start >= 9) break;
            @(posedge clk);
            #1;
        end
        #3;
        rst = 1'b0;
        #1;
        chk(mem_cmd_valid == 1'b0, "abort_cmd_valid", 512'(mem_cmd_valid), 512'(0));
        chk(mem_cmd_we == 1'b0, "abort_cmd_we", 512'(mem_cmd_we), 512'(0));
        chk(mem_cmd_addr == '0, "abort_cmd_addr", 512'(mem_cmd_addr), 512'(0));
        chk(mem_wdata == '0, "abort_wdata", 512'(mem_wdata), 512'(0));
        chk(resp_valid == 1'b0, "abort_resp_valid", 512'(resp_valid), 512'(0));
        chk(resp_data == '0, "abort_resp_data", resp_data, 512'(0));
        chk(log_n - log_start == 9, "abort_beats", 512'(log_n - log_start), 512'(9));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk(req_ready == 1'b1, "abort_req_ready", 512'(req_ready), 512'(1));
        repeat (40) @(posedge clk);
        #1;
        s0m = resp_cnt - r0m;
        chk(s0m == 0, "abort_no_resp", 512'(s0m), 512'(0));
        run_txn(vecs[1], "post_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
